// File: rtl/riscv_multicycle_controller.sv
// rtl/riscv_multicycle_controller.sv - multicycle RISC-V main controller FSM with embedded ALU and immediate decoders
// Optional BNE_EN: the branch state also handles bne and flags any other branch funct3 as illegal.
module riscv_multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7_5,
  input  logic               Zero,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ImmSrc,
  output logic               RegWrite,
  output logic [2:0]         ALUControl,
  output logic               Illegal,
  output logic [STATE_W-1:0] State
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECUTER = STATE_W'(6),
    EXECUTEI = STATE_W'(7),
    ALUWB    = STATE_W'(8),
    BEQ      = STATE_W'(9),
    JAL      = STATE_W'(10)
  } state_t;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // Moore control word for each state; unlisted fields stay 0.
  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.ir_write   = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
        c.pc_update  = 1'b1;
      end
      DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      MEMREAD:  c.adr_src = 1'b1;
      MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      EXECUTER: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      EXECUTEI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      ALUWB:    c.reg_write = 1'b1;
      BEQ: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
        c.branch    = 1'b1;
      end
      JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_update = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;
  logic   decode_illegal;
  logic   branch_ok;
  logic   branch_illegal;

  always_comb begin
    state_next     = FETCH;
    decode_illegal = 1'b0;
    case (state)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECUTER;
          OP_I:         state_next = EXECUTEI;
          OP_BEQ:       state_next = BEQ;
          OP_JAL:       state_next = JAL;
          default:      decode_illegal = 1'b1;
        endcase
      end
      MEMADR:   state_next = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  state_next = MEMWB;
      EXECUTER: state_next = ALUWB;
      EXECUTEI: state_next = ALUWB;
      JAL:      state_next = ALUWB;
      default:  state_next = FETCH;
    endcase
  end

  // Control word is registered alongside the state so it tracks it exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      ctrl  <= ctrl_for(FETCH);
    end else begin
      state <= state_next;
      ctrl  <= ctrl_for(state_next);
    end
  end

`ifdef BNE_EN
  always_comb begin
    branch_ok      = 1'b0;
    branch_illegal = 1'b0;
    case (funct3)
      3'b000:  branch_ok = Zero;
      3'b001:  branch_ok = ~Zero;
      default: branch_illegal = ctrl.branch;
    endcase
  end
`else
  assign branch_ok      = Zero;
  assign branch_illegal = 1'b0;
`endif

  always_comb begin
    ALUControl = 3'b000;
    case (ctrl.alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7_5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          3'b101:  ALUControl = funct7_5 ? 3'b110 : 3'b000;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Write enables and Illegal are held low for as long as reset is high.
  assign PCWrite   = ~reset & (ctrl.pc_update | (ctrl.branch & branch_ok));
  assign IRWrite   = ~reset & ctrl.ir_write;
  assign RegWrite  = ~reset & ctrl.reg_write;
  assign MemWrite  = ~reset & ctrl.mem_write;
  assign Illegal   = ~reset & (decode_illegal | branch_illegal);
  assign AdrSrc    = ctrl.adr_src;
  assign ResultSrc = ctrl.result_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign State     = state;

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// tb/tb_riscv_multicycle_controller.sv - self-checking bench for riscv_multicycle_controller
// Reference model: per-instruction state walks and per-state control tables.
module tb_riscv_multicycle_controller;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [16:0] RESET_MASK = 17'b0_1_0_0_11_11_11_11_0_111_0;

  typedef int iq_t[$];

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;
  logic [16:0] obs_out;

  int n_cmp = 0;
  int n_bad = 0;

  riscv_multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7_5(funct7_5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .RegWrite(RegWrite), .ALUControl(ALUControl), .Illegal(Illegal), .State(State)
  );

  always #5 clk = ~clk;

  assign obs_out = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                    ImmSrc, RegWrite, ALUControl, Illegal};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] o);
    return o inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};
  endfunction

  // Architectural walk of each instruction class through the controller states.
  function automatic iq_t seq_for(input logic [6:0] o);
    iq_t q;
    case (o)
      OP_LW:   q = {0, 1, 2, 3, 4};
      OP_SW:   q = {0, 1, 2, 5};
      OP_R:    q = {0, 1, 6, 8};
      OP_I:    q = {0, 1, 7, 8};
      OP_BEQ:  q = {0, 1, 9};
      OP_JAL:  q = {0, 1, 10, 8};
      default: q = {0, 1};
    endcase
    return q;
  endfunction

  function automatic logic [2:0] exec_alu(input logic [6:0] o, input logic [2:0] f3, input logic f75);
    if (f3 == 3'd2) return 3'b101;
    if (f3 == 3'd6) return 3'b011;
    if (f3 == 3'd7) return 3'b010;
    if (f3 == 3'd0 && o[5] && f75) return 3'b001;
    if (f3 == 3'd5 && f75) return 3'b110;
    return 3'b000;
  endfunction

  function automatic logic [16:0] exp_out(input int s, input logic [6:0] o, input logic [2:0] f3,
                                          input logic f75, input logic z);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
    {pcw, adr, mw, irw, rw, ill} = '0;
    {rs, sa, sb} = '0;
    alu = 3'b000;
    imm = (o == OP_SW) ? 2'b01 : (o == OP_BEQ) ? 2'b10 : (o == OP_JAL) ? 2'b11 : 2'b00;
    case (s)
      0:  begin irw = 1; sb = 2'b10; rs = 2'b10; pcw = 1; end
      1:  begin sa = 2'b01; sb = 2'b01; ill = !is_legal(o); end
      2:  begin sa = 2'b10; sb = 2'b01; end
      3:  adr = 1;
      4:  begin rs = 2'b01; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin sa = 2'b10; alu = exec_alu(o, f3, f75); end
      7:  begin sa = 2'b10; sb = 2'b01; alu = exec_alu(o, f3, f75); end
      8:  rw = 1;
      9:  begin
        sa = 2'b10; alu = 3'b001;
`ifdef BNE_EN
        if (f3 == 3'd0) pcw = z;
        else if (f3 == 3'd1) pcw = !z;
        else ill = 1;
`else
        pcw = z;
`endif
      end
      10: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {pcw, adr, mw, irw, rs, sa, sb, imm, rw, alu, ill};
  endfunction

  // Steps through walk positions first..last; entered just after a rising edge.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f75,
                           input int zmode, input int first, input int last);
    iq_t q;
    int  stop;
    q = seq_for(o);
    stop = (last < 0) ? q.size() - 1 : last;
    op = o; funct3 = f3; funct7_5 = f75;
    for (int i = first; i <= stop; i++) begin
      Zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      @(negedge clk);
      check($sformatf("state op=%b step%0d", o, i), 32'(State), q[i]);
      check($sformatf("outputs op=%b f3=%0d state%0d", o, f3, q[i]), 32'(obs_out),
            32'(exp_out(q[i], o, f3, f75, Zero)));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1; op = OP_LW; funct3 = 3'd0; funct7_5 = 1'b0; Zero = 1'b0;
    #2;
    check("reset state", 32'(State), 0);
    check("reset outputs", 32'(obs_out), 32'(exp_out(0, OP_LW, 3'd0, 1'b0, 1'b0) & RESET_MASK));
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(OP_LW,  3'd2, 1'b0, 2, 0, -1);
    run_instr(OP_SW,  3'd2, 1'b0, 2, 0, -1);
    run_instr(OP_R,   3'd0, 1'b1, 2, 0, -1);
    run_instr(OP_R,   3'd0, 1'b0, 2, 0, -1);
    run_instr(OP_R,   3'd5, 1'b1, 2, 0, -1);
    run_instr(OP_I,   3'd0, 1'b1, 2, 0, -1);
    run_instr(OP_I,   3'd7, 1'b0, 2, 0, -1);
    run_instr(OP_BEQ, 3'd0, 1'b0, 1, 0, -1);
    run_instr(OP_BEQ, 3'd0, 1'b0, 0, 0, -1);
    run_instr(OP_JAL, 3'd0, 1'b0, 2, 0, -1);
    run_instr(7'b1111111, 3'd0, 1'b0, 2, 0, -1);
`ifdef BNE_EN
    run_instr(OP_BEQ, 3'd1, 1'b0, 0, 0, -1);
    run_instr(OP_BEQ, 3'd1, 1'b0, 1, 0, -1);
    run_instr(OP_BEQ, 3'd4, 1'b0, 1, 0, -1);
`endif

    // Asynchronous reset in the middle of MEMREAD.
    run_instr(OP_LW, 3'd2, 1'b0, 0, 0, 2);
    check("in memread before reset", 32'(State), 3);
    #2 reset = 1'b1;
    #1;
    check("async reset state", 32'(State), 0);
    check("async reset outputs", 32'(obs_out), 32'(exp_out(0, OP_LW, 3'd2, 1'b0, 1'b0) & RESET_MASK));
    @(negedge clk);
    check("held reset outputs", 32'(obs_out), 32'(exp_out(0, OP_LW, 3'd2, 1'b0, 1'b0) & RESET_MASK));
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("first edge after reset", 32'(State), 1);
    run_instr(OP_LW, 3'd2, 1'b0, 0, 1, -1);

    for (int n = 0; n < 200; n++) begin
      logic [6:0] o;
      case ($urandom_range(0, 7))
        0: o = OP_LW;
        1: o = OP_SW;
        2: o = OP_R;
        3: o = OP_I;
        4: o = OP_BEQ;
        5: o = OP_JAL;
        6: o = 7'b1111111;
        default: o = 7'($urandom);
      endcase
      run_instr(o, 3'($urandom), 1'($urandom), 2, 0, -1);
    end

    @(negedge clk);
    check("final state", 32'(State), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_controller.md
Name: riscv_multicycle_controller

Overview:
Main controller FSM for the multicycle RISC-V datapath: one shared ALU, one unified instruction/data memory, and an instruction register (IR).
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives every datapath mux select and write enable.
- Embeds the ALU decoder and the immediate-format decoder.
- Supports lw, sw, R-type, I-type ALU, beq and jal.

Parameters:
STATE_W, 4, width of state register and State debug port (must be ≥4).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
op  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7_5  in  1  IR[30]
Zero  in  1  ALU zero flag
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0=PC, 1=Result
MemWrite  out  1  memory write enable
IRWrite  out  1  IR and OldPC load enable
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  out  2  00=PC, 01=OldPC, 10=A (rs1)
ALUSrcB  out  2  00=WriteData (rs2), 01=ImmExt, 10=constant 4
ImmSrc  out  2  00=I, 01=S, 10=B, 11=J
RegWrite  out  1  register file write enable
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt, 110 sra
Illegal  out  1  one-cycle pulse when an unsupported opcode is decoded
State  out  STATE_W  current state, for debug

Behaviour:
- Moore FSM; state register updates on the rising clk edge.
- reset asynchronously forces state to FETCH.
- While reset is high, PCWrite/IRWrite/RegWrite/MemWrite/Illegal are forced 0; other outputs take FETCH values.
- Reset deasserted mid-instruction: restart at FETCH with no partial write.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10. All other codes go to FETCH.
- Every output not listed for a state is 0.
- Internal signals:
  - PCUpdate, Branch, ALUOp[1:0].
  - PCWrite = PCUpdate | (Branch & Zero).
- States, outputs and transitions:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BEQ
    - 1101111 → JAL
    - any other op → FETCH, with Illegal=1 for this cycle.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next: FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next: FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB (rd ← OldPC+4).
- Cycles per instruction: lw 5; sw, R-type, I-type, jal 4; beq 3; illegal 2.
- ImmSrc is combinational from op in every state:
  - 0000011 / 0010011 → 00
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - otherwise 00
- ALU decoder, combinational:
  - ALUOp=00 → add
  - ALUOp=01 → sub
  - ALUOp=10, by funct3:
    - 000 → sub if {op[5],funct7_5}=11, else add
    - 010 → slt
    - 110 → or
    - 111 → and
    - 101 → sra if funct7_5=1, else add
    - other → add
- No X values are driven on any output.

Optional Feature:
BNE_EN
- Defined:
  - In BEQ, funct3=000 gives PCWrite=Zero.
  - funct3=001 gives PCWrite=~Zero.
  - Any other funct3 gives PCWrite=0 and Illegal=1 in the BEQ cycle.
- Undefined:
  - Every branch opcode takes beq semantics regardless of funct3.
  - Illegal is never raised in BEQ.

Test Plan:
- reset pulsed mid-MEMREAD → State=0 immediately (asynchronous); no RegWrite/MemWrite asserted; next edge gives State=1.
- lw (op=0000011) → states 0,1,2,3,4,0.
  - MEMWB: RegWrite=1, ResultSrc=01.
  - MEMREAD: AdrSrc=1.
  - PCWrite=1 only in FETCH.
- sw (op=0100011) → states 0,1,2,5,0.
  - MemWrite=1 only in MEMWRITE.
  - ImmSrc=01 throughout.
  - RegWrite never asserted.
- R-type sub (op=0110011, funct3=000, funct7_5=1) → ALUControl=001 in EXECUTER.
  - Same instruction with funct7_5=0 → ALUControl=000.
  - funct3=101, funct7_5=1 → ALUControl=110.
- beq with Zero=1 → PCWrite=1 in the BEQ cycle; with Zero=0 → PCWrite=0. Both return to FETCH after 3 cycles.
- jal (op=1101111) → states 0,1,10,8,0.
  - PCWrite=1 in JAL.
  - ImmSrc=11.
- op=1111111 → Illegal=1 for exactly the DECODE cycle, then FETCH.
- With BNE_EN defined: funct3=001, Zero=0 → PCWrite=1.
